// File: rtl/img_proc_pkg.sv
// ---------------------------------------------------------------------------
// img_proc_pkg
// Shared types and helpers for the streaming 3x3 edge-detection stage.
//   mode_e      : runtime operating mode (passthrough, Gx, Gy, |Gx|+|Gy|)
//   GRAD_GUARD  : extra bits a Sobel sum needs above the pixel width
//   GRAD_W      : gradient width for the default 12-bit pixel
//   sat_abs()   : absolute value clamped to 2^width-1
// ---------------------------------------------------------------------------
package img_proc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GX   = 2'd1,
    MODE_GY   = 2'd2,
    MODE_MAG  = 2'd3
  } mode_e;

  // A 3x3 Sobel kernel sums at most 4 pixels on each side, so two bits of
  // growth plus a sign bit are needed; one spare keeps |Gx|+|Gy| headroom.
  localparam int GRAD_GUARD    = 4;
  localparam int PIX_W_DEFAULT = 12;
  localparam int GRAD_W        = PIX_W_DEFAULT + GRAD_GUARD;

  // |value| clamped to the largest unsigned number representable in width bits.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] value,
                                          input int unsigned         width);
    logic [31:0] v_mag;
    logic [31:0] v_lim;
    v_mag = value[31] ? 32'(-value) : 32'(value);
    v_lim = (32'd1 << width) - 32'd1;
    return (v_mag > v_lim) ? v_lim : v_mag;
  endfunction

endpackage

// File: rtl/img_line_buffer.sv
// ---------------------------------------------------------------------------
// img_line_buffer
// One line of pixel storage addressed by column. The read port is
// combinational so the old value at i_addr is returned in the same cycle it
// is overwritten (read-before-write); this lets two buffers be cascaded on a
// shared address without a column skew.
//   i_clk  : clock
//   i_we   : write enable (one accepted pixel)
//   i_addr : column address
//   i_data : value to store at i_addr
//   o_data : value held at i_addr before this cycle's write
// Contents are never reset.
// ---------------------------------------------------------------------------
module img_line_buffer #(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 12,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_data;
    end
  end

  assign o_data = r_mem[i_addr];

endmodule

// File: rtl/image_proc_sobel_stream.sv
// ---------------------------------------------------------------------------
// image_proc_sobel_stream
// Streaming 3x3 Sobel stage: two cascaded line buffers plus a register
// window produce Gx / Gy / |Gx|+|Gy| (or passthrough) with saturation and
// zeroed borders. Fixed 2-cycle latency, no backpressure.
//   iCLK    : pixel clock
//   iRST    : asynchronous active-high reset
//   iDATA   : unsigned gray pixel, raster order
//   iDVAL   : iDATA valid
//   iSOF    : start-of-frame resync
//   iMODE   : 0 pass, 1 |Gx|, 2 |Gy|, 3 |Gx|+|Gy| (latched at pixel (0,0))
//   iTHRESH : binarisation threshold (only with IMG_PROC_THRESHOLD_EN)
//   oDATA   : processed pixel (holds while oDVAL is low)
//   oDVAL   : oDATA valid, iDVAL delayed by two cycles
//   oEOF    : marks the last pixel of the frame
// Build option: define IMG_PROC_THRESHOLD_EN to add iTHRESH and a binary
// output (all ones when the saturated result >= threshold, else zero).
// ---------------------------------------------------------------------------
module image_proc_sobel_stream
  import img_proc_pkg::*;
#(
  parameter int PIX_W = 12,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [PIX_W-1:0] iDATA,
  input  logic             iDVAL,
  input  logic             iSOF,
  input  logic [1:0]       iMODE,
`ifdef IMG_PROC_THRESHOLD_EN
  input  logic [PIX_W-1:0] iTHRESH,
`endif
  output logic [PIX_W-1:0] oDATA,
  output logic             oDVAL,
  output logic             oEOF
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int W_G = PIX_W + GRAD_GUARD;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // ---------------- position tracking ----------------
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_origin;

  // iSOF forces the pixel presented in the same cycle to be (0,0).
  assign w_x      = iSOF ? '0 : r_x;
  assign w_y      = iSOF ? '0 : r_y;
  assign w_origin = (w_x == '0) && (w_y == '0);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_x <= '0;
      r_y <= '0;
    end else if (iDVAL) begin
      if (w_x == X_LAST) begin
        r_x <= '0;
        r_y <= (w_y == Y_LAST) ? '0 : w_y + YW'(1);
      end else begin
        r_x <= w_x + XW'(1);
        r_y <= w_y;
      end
    end else if (iSOF) begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  // ---------------- frame-locked configuration ----------------
  mode_e r_mode;
`ifdef IMG_PROC_THRESHOLD_EN
  logic [PIX_W-1:0] r_thresh;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_mode   <= MODE_PASS;
`ifdef IMG_PROC_THRESHOLD_EN
      r_thresh <= '0;
`endif
    end else if (iDVAL && w_origin) begin
      r_mode   <= mode_e'(iMODE);
`ifdef IMG_PROC_THRESHOLD_EN
      r_thresh <= iTHRESH;
`endif
    end
  end

  // ---------------- cascaded line buffers ----------------
  // Buffer 0 returns line y-1 and stores the current pixel; its old value
  // is pushed into buffer 1, which therefore returns line y-2.
  logic [PIX_W-1:0] w_lb_in  [2];
  logic [PIX_W-1:0] w_lb_out [2];

  assign w_lb_in[0] = iDATA;
  assign w_lb_in[1] = w_lb_out[0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lb
      img_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
      ) u_lb (
        .i_clk  (iCLK),
        .i_we   (iDVAL),
        .i_addr (w_x),
        .i_data (w_lb_in[gi]),
        .o_data (w_lb_out[gi])
      );
    end
  endgenerate

  // ---------------- stage 1: window and flags ----------------
  // r_win[row][col]: row 0 = line y-2, col 0 = column x-2.
  logic [PIX_W-1:0] r_win [3][3];
  logic [PIX_W-1:0] w_col [3];
  logic             r_v1;
  logic             r_border1;
  logic             r_eof1;

  assign w_col[0] = w_lb_out[1];
  assign w_col[1] = w_lb_out[0];
  assign w_col[2] = iDATA;

  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
        r_win[r][2] <= w_col[r];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_v1      <= 1'b0;
      r_border1 <= 1'b0;
      r_eof1    <= 1'b0;
    end else begin
      r_v1 <= iDVAL;
      if (iDVAL) begin
        // Window columns/rows left of/above the frame hold stale data.
        r_border1 <= (w_x < XW'(2)) || (w_y < YW'(2));
        r_eof1    <= (w_x == X_LAST) && (w_y == Y_LAST);
      end
    end
  end

  // ---------------- stage 2: arithmetic and selection ----------------
  function automatic logic signed [W_G-1:0] f_ext(input logic [PIX_W-1:0] p);
    return $signed({{GRAD_GUARD{1'b0}}, p});
  endfunction

  logic signed [W_G-1:0] w_gx;
  logic signed [W_G-1:0] w_gy;
  logic [31:0]           w_gx32;
  logic [31:0]           w_gy32;
  logic [31:0]           w_abs_x;
  logic [31:0]           w_abs_y;
  logic [PIX_W-1:0]      w_sat_x;
  logic [PIX_W-1:0]      w_sat_y;
  logic [PIX_W-1:0]      w_sat_m;
  logic [PIX_W-1:0]      w_result;
  logic [PIX_W-1:0]      w_final;

  assign w_gx = (f_ext(r_win[0][2]) + (f_ext(r_win[1][2]) <<< 1) + f_ext(r_win[2][2]))
              - (f_ext(r_win[0][0]) + (f_ext(r_win[1][0]) <<< 1) + f_ext(r_win[2][0]));
  assign w_gy = (f_ext(r_win[2][0]) + (f_ext(r_win[2][1]) <<< 1) + f_ext(r_win[2][2]))
              - (f_ext(r_win[0][0]) + (f_ext(r_win[0][1]) <<< 1) + f_ext(r_win[0][2]));

  assign w_gx32 = {{(32-W_G){w_gx[W_G-1]}}, w_gx};
  assign w_gy32 = {{(32-W_G){w_gy[W_G-1]}}, w_gy};

  // Full-precision magnitudes feed the sum so |Gx|+|Gy| saturates once,
  // instead of adding two already-clamped values.
  assign w_abs_x = sat_abs(w_gx32, W_G);
  assign w_abs_y = sat_abs(w_gy32, W_G);
  assign w_sat_x = PIX_W'(sat_abs(w_gx32, PIX_W));
  assign w_sat_y = PIX_W'(sat_abs(w_gy32, PIX_W));
  assign w_sat_m = PIX_W'(sat_abs(w_abs_x + w_abs_y, PIX_W));

  always_comb begin
    w_result = '0;
    unique case (r_mode)
      MODE_PASS: w_result = r_win[2][2];
      MODE_GX:   w_result = r_border1 ? '0 : w_sat_x;
      MODE_GY:   w_result = r_border1 ? '0 : w_sat_y;
      MODE_MAG:  w_result = r_border1 ? '0 : w_sat_m;
      default:   w_result = '0;
    endcase
  end

`ifdef IMG_PROC_THRESHOLD_EN
  assign w_final = (w_result >= r_thresh) ? {PIX_W{1'b1}} : '0;
`else
  assign w_final = w_result;
`endif

  logic [PIX_W-1:0] r_out_data;
  logic             r_out_dval;
  logic             r_out_eof;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_out_data <= '0;
      r_out_dval <= 1'b0;
      r_out_eof  <= 1'b0;
    end else begin
      r_out_dval <= r_v1;
      r_out_eof  <= r_v1 & r_eof1;
      if (r_v1) begin
        r_out_data <= w_final;
      end
    end
  end

  assign oDATA = r_out_data;
  assign oDVAL = r_out_dval;
  assign oEOF  = r_out_eof;

endmodule

// File: tb/tb_image_proc_sobel_stream.sv
// ---------------------------------------------------------------------------
// tb_image_proc_sobel_stream
// Scoreboard bench: the stimulus side computes each expected output from a
// frame image held in an array and pushes it into a queue; an independent
// monitor pops and compares whenever oDVAL is seen.
// ---------------------------------------------------------------------------
module tb_image_proc_sobel_stream;

  localparam int PW = 8;
  localparam int IW = 8;
  localparam int IH = 4;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic [PW-1:0] din  = '0;
  logic          dval = 1'b0;
  logic          sof  = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [PW-1:0] dout;
  logic          odval;
  logic          oeof;
`ifdef IMG_PROC_THRESHOLD_EN
  logic [PW-1:0] thresh = 8'd100;
`endif

  always #5 clk = ~clk;

  image_proc_sobel_stream #(
    .PIX_W (PW),
    .IMG_W (IW),
    .IMG_H (IH)
  ) dut (
    .iCLK    (clk),
    .iRST    (rst),
    .iDATA   (din),
    .iDVAL   (dval),
    .iSOF    (sof),
    .iMODE   (mode),
`ifdef IMG_PROC_THRESHOLD_EN
    .iTHRESH (thresh),
`endif
    .oDATA   (dout),
    .oDVAL   (odval),
    .oEOF    (oeof)
  );

  typedef struct {
    logic [PW-1:0] data;
    logic          eof;
    int            stamp;
    int            idx;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   out_cnt = 0;
  int   tx_idx  = 0;

  // Reference frame state
  int img [IH][IW];
  int mx    = 0;
  int my    = 0;
  int mmode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected output for the pixel at (x,y) straight from the kernel definition.
  function automatic int model_out(input int x, input int y, input int m);
    int gx, gy, v;
    if (m == 0) begin
      v = img[y][x];
    end else if (x < 2 || y < 2) begin
      v = 0;
    end else begin
      gx = (img[y-2][x] + 2*img[y-1][x] + img[y][x])
         - (img[y-2][x-2] + 2*img[y-1][x-2] + img[y][x-2]);
      gy = (img[y][x-2] + 2*img[y][x-1] + img[y][x])
         - (img[y-2][x-2] + 2*img[y-2][x-1] + img[y-2][x]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      v = (m == 1) ? gx : (m == 2) ? gy : gx + gy;
      if (v > 255) v = 255;
    end
`ifdef IMG_PROC_THRESHOLD_EN
    v = (v >= 100) ? 255 : 0;
`endif
    return v;
  endfunction

  task automatic send(input logic [PW-1:0] d, input logic s, input logic [1:0] m);
    exp_t e;
    @(negedge clk);
    din  = d;
    dval = 1'b1;
    sof  = s;
    mode = m;
    if (s) begin
      mx = 0;
      my = 0;
    end
    if (mx == 0 && my == 0) mmode = int'(m);
    img[my][mx] = int'(d);
    e.data  = 8'(model_out(mx, my, mmode));
    e.eof   = (mx == IW-1) && (my == IH-1);
    e.stamp = cyc + 2;
    e.idx   = tx_idx++;
    q.push_back(e);
    if (mx == IW-1) begin
      mx = 0;
      my = (my == IH-1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  task automatic idle(input logic s);
    @(negedge clk);
    dval = 1'b0;
    sof  = s;
    if (s) begin
      mx = 0;
      my = 0;
    end
  endtask

  task automatic drain();
    idle(1'b0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    check("drain_pending", q.size(), 0);
  endtask

  // Monitor: pops one expectation per output beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && odval) begin
        out_cnt++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_dval: got oDVAL=1 data=%0d, expected no output", dout);
        end else begin
          mon_e = q.pop_front();
          check("data", dout, mon_e.data);
          check("eof", oeof, mon_e.eof);
          check("latency", cyc, mon_e.stamp);
          $display("[TB] tx %0d data=%0d eof=%0d", mon_e.idx, dout, oeof);
        end
      end else if (!rst && oeof) begin
        check("eof_without_dval", oeof, 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_odata", dout, 0);
    check("rst_odval", odval, 0);
    check("rst_oeof", oeof, 0);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0 ramp: output equals input, oEOF on value 31
    for (int p = 0; p < 32; p++) send(8'(p), p == 0, 2'd0);
    drain();

    // Mode 1 constant image: all zeros, 32 beats per frame
    c0 = out_cnt;
    for (int p = 0; p < 32; p++) send(8'd50, p == 0, 2'd1);
    drain();
    check("frame_dval_count", out_cnt - c0, 32);

    // Mode 1 vertical step 0|100
    for (int p = 0; p < 32; p++) send(((p % IW) < 4) ? 8'd0 : 8'd100, p == 0, 2'd1);
    drain();

    // Mode 3 vertical step 0|255: magnitude saturates
    for (int p = 0; p < 32; p++) send(((p % IW) < 4) ? 8'd0 : 8'd255, p == 0, 2'd3);
    drain();

    // Mid-frame mode change is ignored until next frame
    for (int p = 0; p < 32; p++) send(8'($urandom_range(0, 255)), p == 0, (p < 10) ? 2'd0 : 2'd1);
    for (int p = 0; p < 32; p++) send(8'($urandom_range(0, 255)), 1'b0, 2'd1);
    drain();

    // iSOF with iDVAL at pixel 5 restarts the frame
    for (int p = 0; p < 5; p++) send(8'($urandom_range(0, 255)), p == 0, 2'd2);
    for (int p = 0; p < 32; p++) send(8'($urandom_range(0, 255)), p == 0, 2'd2);
    drain();

    // iSOF without iDVAL
    for (int p = 0; p < 12; p++) send(8'($urandom_range(0, 255)), p == 0, 2'd3);
    idle(1'b1);
    for (int p = 0; p < 32; p++) send(8'($urandom_range(0, 255)), 1'b0, 2'd3);
    drain();

    // Random modes, data and iDVAL gaps
    for (int f = 0; f < 4; f++) begin
      logic [1:0] fm;
      fm = 2'($urandom_range(0, 3));
      for (int p = 0; p < 32; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          int ng;
          ng = $urandom_range(1, 3);
          for (int g = 0; g < ng; g++) idle(1'b0);
        end
        send(8'($urandom_range(0, 255)), p == 0, fm);
      end
    end
    drain();

    // Reset with pixels in flight: nothing may come out
    send(8'd77, 1'b1, 2'd0);
    @(negedge clk);
    din  = 8'hAA;
    dval = 1'b1;
    sof  = 1'b0;
    rst  = 1'b1;
    q.delete();
    mx = 0;
    my = 0;
    mmode = 0;
    #1;
    check("rst_flush_odval", odval, 0);
    @(negedge clk);
    dval = 1'b0;
    check("rst_hold_odval", odval, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_odval", odval, 0);
    end

    // After reset the next pixel is (0,0) without iSOF
    for (int p = 0; p < 32; p++) send(8'($urandom_range(0, 255)), 1'b0, 2'd2);
    drain();
    for (int p = 0; p < 32; p++) send(8'($urandom_range(0, 255)), 1'b0, 2'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
